decode_issue_unit: RTL and testbench

- Buffered, scoreboarded successor to the single-cycle instruction decoder.
- Accepts fetched words into a DEPTH-entry queue and decodes the queue head into datapath control.
- Holds each decoded instruction in an issue register until it is handshaken downstream.
- Tracks in-flight register writes and stalls on RAW/WAW hazards. Supports flush and a sticky halt.

---
 rtl/decode_issue_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_decode_issue_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_unit.sv
// ---------------------------------------------------------------------------
// decode_issue_unit
//
// Buffered, scoreboarded instruction decoder. Fetched words land in a
// DEPTH-entry queue; the queue head is decoded combinationally and moved into
// an issue register once it is free of RAW/WAW hazards. The issue register
// holds the decoded instruction until the downstream stage handshakes it.
// A per-register busy scoreboard tracks writes that have issued but not yet
// retired. A HALT instruction makes the unit stop accepting and issuing
// until reset.
//
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   fetch_valid/ready      fetch handshake; fetch_ins/fetch_npc word and PC+4
//   iss_valid/ready        issue handshake
//   iss_*                  decoded control fields of the issued instruction
//   wb_valid, wb_sel       retiring register write (clears the busy bit)
//   flush                  discard queue and issue register
//   halted                 sticky halt flag
// ---------------------------------------------------------------------------
module decode_issue_unit #(
    parameter int DEPTH = 4,
    parameter int NREGS = 32,
    parameter int RBITS = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_ins,
    input  logic [31:0]      fetch_npc,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [3:0]       iss_op,
    output logic [RBITS-1:0] iss_rsel1,
    output logic [RBITS-1:0] iss_rsel2,
    output logic [RBITS-1:0] iss_wsel,
    output logic             iss_WEN,
    output logic             iss_dREN,
    output logic             iss_dWEN,
    output logic             iss_datomic,
    output logic             iss_halt,
    output logic [1:0]       iss_pcSel,
    output logic [1:0]       iss_aluBSel,
    output logic [1:0]       iss_rfInSel,
    output logic             iss_brne,
    output logic             iss_illegal,
    output logic [15:0]      iss_imm16,
    output logic [25:0]      iss_immJ26,
    output logic [4:0]       iss_shamt,
    output logic [31:0]      iss_npc,
    input  logic             wb_valid,
    input  logic [RBITS-1:0] wb_sel,
    input  logic             flush,
    output logic             halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    localparam logic [1:0] PC_NPC  = 2'd0, PC_BR  = 2'd1, PC_JR    = 2'd2, PC_JUMP = 2'd3;
    localparam logic [1:0] B_RDAT  = 2'd0, B_EXT  = 2'd1, B_SHAMT  = 2'd2;
    localparam logic [1:0] RF_ALU  = 2'd0, RF_NPC = 2'd1, RF_LUI   = 2'd2, RF_RAM  = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30, OP_SC   = 6'h38, OP_HALT = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_JR   = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]       op;
        logic [RBITS-1:0] rsel1;
        logic [RBITS-1:0] rsel2;
        logic [RBITS-1:0] wsel;
        logic             wen;
        logic             dren;
        logic             dwen;
        logic             datomic;
        logic             halt;
        logic [1:0]       pcSel;
        logic [1:0]       aluBSel;
        logic [1:0]       rfInSel;
        logic             brne;
        logic             illegal;
        logic [15:0]      imm16;
        logic [25:0]      immJ26;
        logic [4:0]       shamt;
        logic [31:0]      npc;
    } decoded_t;

    logic [31:0]      r_qIns [DEPTH];
    logic [31:0]      r_qNpc [DEPTH];
    logic [PW-1:0]    r_rdPtr, r_wrPtr;
    logic [CW-1:0]    r_count;
    logic             r_issValid;
    decoded_t         r_iss;
    logic [NREGS-1:0] r_busy;
    logic             r_halted;

    logic [31:0]      w_head, w_headNpc;
    logic [5:0]       w_opcode, w_funct;
    logic [RBITS-1:0] w_rs, w_rt, w_rd;
    decoded_t         w_dec;
    logic             w_rsUsed, w_rtUsed;
    logic             w_full, w_push, w_load, w_hazard, w_sbSet;
    logic [NREGS-1:0] w_busyNext;

    assign w_head    = r_qIns[r_rdPtr];
    assign w_headNpc = r_qNpc[r_rdPtr];
    assign w_opcode  = w_head[31:26];
    assign w_funct   = w_head[5:0];
    assign w_rs      = RBITS'(w_head[25:21]);
    assign w_rt      = RBITS'(w_head[20:16]);
    assign w_rd      = RBITS'(w_head[15:11]);

    assign w_full      = (r_count == CW'(DEPTH));
    assign fetch_ready = !w_full && !r_halted;
    assign w_push      = fetch_valid && fetch_ready && !flush;

    // Decode the queue head. Everything starts at zero so unused fields never
    // float; the immediate slices and PC+4 are always passed through.
    always_comb begin
        w_dec        = '0;
        w_rsUsed     = 1'b0;
        w_rtUsed     = 1'b0;
        w_dec.imm16  = w_head[15:0];
        w_dec.immJ26 = w_head[25:0];
        w_dec.shamt  = w_head[10:6];
        w_dec.npc    = w_headNpc;
        case (w_opcode)
            OP_RTYPE: begin
                w_rsUsed      = 1'b1;
                w_rtUsed      = 1'b1;
                w_dec.rsel1   = w_rs;
                w_dec.rsel2   = w_rt;
                w_dec.wsel    = w_rd;
                w_dec.wen     = 1'b1;
                w_dec.aluBSel = B_RDAT;
                case (w_funct)
                    F_SLL:         begin w_dec.op = ALU_SLL; w_dec.aluBSel = B_SHAMT; end
                    F_SRL:         begin w_dec.op = ALU_SRL; w_dec.aluBSel = B_SHAMT; end
                    F_JR:          begin w_dec.wen = 1'b0; w_dec.wsel = '0; w_dec.pcSel = PC_JR; end
                    F_ADD, F_ADDU: w_dec.op = ALU_ADD;
                    F_SUB, F_SUBU: w_dec.op = ALU_SUB;
                    F_AND:         w_dec.op = ALU_AND;
                    F_OR:          w_dec.op = ALU_OR;
                    F_XOR:         w_dec.op = ALU_XOR;
                    F_NOR:         w_dec.op = ALU_NOR;
                    F_SLT:         w_dec.op = ALU_SLT;
                    F_SLTU:        w_dec.op = ALU_SLTU;
                    default: begin
                        w_dec.rsel1   = '0;
                        w_dec.rsel2   = '0;
                        w_dec.wsel    = '0;
                        w_dec.wen     = 1'b0;
                        w_dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_J: w_dec.pcSel = PC_JUMP;
            OP_JAL: begin
                w_dec.pcSel   = PC_JUMP;
                w_dec.wsel    = RBITS'(31);
                w_dec.wen     = 1'b1;
                w_dec.rfInSel = RF_NPC;
            end
            OP_BEQ, OP_BNE: begin
                w_rsUsed      = 1'b1;
                w_rtUsed      = 1'b1;
                w_dec.rsel1   = w_rs;
                w_dec.rsel2   = w_rt;
                w_dec.pcSel   = PC_BR;
                w_dec.aluBSel = B_RDAT;
                w_dec.op      = ALU_SUB;
                w_dec.brne    = (w_opcode == OP_BNE);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                w_rsUsed      = 1'b1;
                w_dec.rsel1   = w_rs;
                w_dec.wsel    = w_rt;
                w_dec.wen     = 1'b1;
                w_dec.aluBSel = B_EXT;
                case (w_opcode)
                    OP_SLTI:  w_dec.op = ALU_SLT;
                    OP_SLTIU: w_dec.op = ALU_SLTU;
                    OP_ANDI:  w_dec.op = ALU_AND;
                    OP_ORI:   w_dec.op = ALU_OR;
                    OP_XORI:  w_dec.op = ALU_XOR;
                    default:  w_dec.op = ALU_ADD;
                endcase
            end
            OP_LUI: begin
                w_dec.wsel    = w_rt;
                w_dec.wen     = 1'b1;
                w_dec.rfInSel = RF_LUI;
            end
            OP_LW, OP_LL: begin
                w_rsUsed      = 1'b1;
                w_dec.rsel1   = w_rs;
                w_dec.wsel    = w_rt;
                w_dec.wen     = 1'b1;
                w_dec.aluBSel = B_EXT;
                w_dec.op      = ALU_ADD;
                w_dec.dren    = 1'b1;
                w_dec.rfInSel = RF_RAM;
                w_dec.datomic = (w_opcode == OP_LL);
            end
            OP_SW, OP_SC: begin
                w_rsUsed      = 1'b1;
                w_rtUsed      = 1'b1;
                w_dec.rsel1   = w_rs;
                w_dec.rsel2   = w_rt;
                w_dec.aluBSel = B_EXT;
                w_dec.op      = ALU_ADD;
                w_dec.dwen    = 1'b1;
                // SC also writes its success flag back into rt.
                if (w_opcode == OP_SC) begin
                    w_dec.datomic = 1'b1;
                    w_dec.wen     = 1'b1;
                    w_dec.wsel    = w_rt;
                    w_dec.rfInSel = RF_RAM;
                end
            end
            OP_HALT: w_dec.halt = 1'b1;
            default: begin
                w_rsUsed      = 1'b1;
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Hazard detection: sources and destination against both the retired-
    // pending scoreboard and the write still sitting in the issue register.
    always_comb begin
        w_hazard = 1'b0;
        if ((w_rsUsed && r_busy[w_rs]) || (w_rtUsed && r_busy[w_rt]) ||
            (w_dec.wen && (w_dec.wsel != '0) && r_busy[w_dec.wsel]))
            w_hazard = 1'b1;
        if (r_issValid && r_iss.wen &&
            ((w_rsUsed && (w_rs == r_iss.wsel)) || (w_rtUsed && (w_rt == r_iss.wsel)) ||
             (w_dec.wen && (w_dec.wsel != '0) && (w_dec.wsel == r_iss.wsel))))
            w_hazard = 1'b1;
    end

    assign w_load  = (r_count != '0) && !w_hazard && !r_halted && !flush &&
                     (!r_issValid || iss_ready);
    assign w_sbSet = r_issValid && iss_ready && r_iss.wen && (r_iss.wsel != '0);

    // Scoreboard next state: clear first so a same-cycle set wins; register 0
    // is forced idle.
    always_comb begin
        w_busyNext = r_busy;
        if (wb_valid)
            w_busyNext[wb_sel] = 1'b0;
        if (w_sbSet)
            w_busyNext[r_iss.wsel] = 1'b1;
        w_busyNext[0] = 1'b0;
    end

    // Queue storage needs no reset; only the pointers and count define
    // which entries are live.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_qIns[r_wrPtr] <= fetch_ins;
            r_qNpc[r_wrPtr] <= fetch_npc;
        end
    end

    // Queue control, issue register, scoreboard and halt flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_issValid <= 1'b0;
            r_iss      <= '0;
            r_busy     <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            if (flush) begin
                r_rdPtr    <= '0;
                r_wrPtr    <= '0;
                r_count    <= '0;
                r_issValid <= 1'b0;
            end else begin
                if (w_push)
                    r_wrPtr <= r_wrPtr + PW'(1);
                if (w_load)
                    r_rdPtr <= r_rdPtr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_load);
                if (w_load) begin
                    r_issValid <= 1'b1;
                    r_iss      <= w_dec;
                    if (w_dec.halt)
                        r_halted <= 1'b1;
                end else if (iss_ready) begin
                    r_issValid <= 1'b0;
                end
            end
        end
    end

    assign iss_valid   = r_issValid;
    assign iss_op      = r_iss.op;
    assign iss_rsel1   = r_iss.rsel1;
    assign iss_rsel2   = r_iss.rsel2;
    assign iss_wsel    = r_iss.wsel;
    assign iss_WEN     = r_iss.wen;
    assign iss_dREN    = r_iss.dren;
    assign iss_dWEN    = r_iss.dwen;
    assign iss_datomic = r_iss.datomic;
    assign iss_halt    = r_iss.halt;
    assign iss_pcSel   = r_iss.pcSel;
    assign iss_aluBSel = r_iss.aluBSel;
    assign iss_rfInSel = r_iss.rfInSel;
    assign iss_brne    = r_iss.brne;
    assign iss_illegal = r_iss.illegal;
    assign iss_imm16   = r_iss.imm16;
    assign iss_immJ26  = r_iss.immJ26;
    assign iss_shamt   = r_iss.shamt;
    assign iss_npc     = r_iss.npc;
    assign halted      = r_halted;

endmodule

// File: tb/tb_decode_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_unit
//
// Directed bench for decode_issue_unit: latency, RAW stall on the
// scoreboard, queue fill and pointer wrap, flush, sticky halt, illegal
// opcode and writes to register 0. Expected values are hand-computed from
// the instruction encodings.
// ---------------------------------------------------------------------------
module tb_decode_issue_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_ins = '0;
    logic [31:0] fetch_npc = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [3:0]  iss_op;
    logic [4:0]  iss_rsel1, iss_rsel2, iss_wsel;
    logic        iss_WEN, iss_dREN, iss_dWEN, iss_datomic, iss_halt;
    logic [1:0]  iss_pcSel, iss_aluBSel, iss_rfInSel;
    logic        iss_brne, iss_illegal;
    logic [15:0] iss_imm16;
    logic [25:0] iss_immJ26;
    logic [4:0]  iss_shamt;
    logic [31:0] iss_npc;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_sel = '0;
    logic        flush = 1'b0;
    logic        halted;

    int checkCount = 0;
    int failCount  = 0;

    decode_issue_unit #(.DEPTH(4), .NREGS(32), .RBITS(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_ins(fetch_ins), .fetch_npc(fetch_npc),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_rsel1(iss_rsel1), .iss_rsel2(iss_rsel2), .iss_wsel(iss_wsel),
        .iss_WEN(iss_WEN), .iss_dREN(iss_dREN), .iss_dWEN(iss_dWEN),
        .iss_datomic(iss_datomic), .iss_halt(iss_halt),
        .iss_pcSel(iss_pcSel), .iss_aluBSel(iss_aluBSel), .iss_rfInSel(iss_rfInSel),
        .iss_brne(iss_brne), .iss_illegal(iss_illegal),
        .iss_imm16(iss_imm16), .iss_immJ26(iss_immJ26), .iss_shamt(iss_shamt),
        .iss_npc(iss_npc),
        .wb_valid(wb_valid), .wb_sel(wb_sel),
        .flush(flush), .halted(halted)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Single comparison point; every check in the bench comes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] ins, input logic [31:0] npc);
        fetch_valid = valid;
        fetch_ins   = ins;
        fetch_npc   = npc;
    endtask

    // Push one word and give it the single extra edge needed to load.
    task automatic pushAndIssue(input logic [31:0] ins, input logic [31:0] npc);
        applyStimulus(1'b1, ins, npc);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(1);
    endtask

    task automatic doReset();
        nRST      = 1'b0;
        iss_ready = 1'b0;
        wb_valid  = 1'b0;
        wb_sel    = '0;
        flush     = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(2);
        nRST = 1'b1;
    endtask

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ---------------- reset state, ADDU latency and decode
        doReset();
        checkOutput("rst_iss_valid", 32'(iss_valid), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        checkOutput("rst_iss_op", 32'(iss_op), 32'd0);
        checkOutput("rst_iss_wsel", 32'(iss_wsel), 32'd0);

        applyStimulus(1'b1, 32'h00221821, 32'h00000104);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("addu_lat_edge1", 32'(iss_valid), 32'd0);
        step(1);
        checkOutput("addu_valid", 32'(iss_valid), 32'd1);
        checkOutput("addu_op", 32'(iss_op), 32'd2);
        checkOutput("addu_wsel", 32'(iss_wsel), 32'd3);
        checkOutput("addu_rsel1", 32'(iss_rsel1), 32'd1);
        checkOutput("addu_rsel2", 32'(iss_rsel2), 32'd2);
        checkOutput("addu_wen", 32'(iss_WEN), 32'd1);
        checkOutput("addu_alub", 32'(iss_aluBSel), 32'd0);
        checkOutput("addu_npc", iss_npc, 32'h00000104);

        iss_ready = 1'b1;
        step(1);
        checkOutput("addu_drained", 32'(iss_valid), 32'd0);
        // ADDU $6,$3,$1 must wait for $3 to retire.
        applyStimulus(1'b1, 32'h00613021, 32'h00000108);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(2);
        checkOutput("busy3_stall", 32'(iss_valid), 32'd0);
        wb_valid = 1'b1;
        wb_sel   = 5'd3;
        step(1);
        wb_valid = 1'b0;
        checkOutput("busy3_no_bypass", 32'(iss_valid), 32'd0);
        step(1);
        checkOutput("busy3_released", 32'(iss_valid), 32'd1);
        checkOutput("busy3_wsel", 32'(iss_wsel), 32'd6);

        // ---------------- LW then dependent ADD
        doReset();
        iss_ready = 1'b1;
        applyStimulus(1'b1, 32'h8C240000, 32'h00000204);
        step(1);
        applyStimulus(1'b1, 32'h00842820, 32'h00000208);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("lw_dren", 32'(iss_dREN), 32'd1);
        checkOutput("lw_rfin", 32'(iss_rfInSel), 32'd3);
        checkOutput("lw_alub", 32'(iss_aluBSel), 32'd1);
        checkOutput("lw_wsel", 32'(iss_wsel), 32'd4);
        step(3);
        checkOutput("add_held", 32'(iss_valid), 32'd0);
        wb_valid = 1'b1;
        wb_sel   = 5'd4;
        step(1);
        wb_valid = 1'b0;
        checkOutput("add_held_wb_edge", 32'(iss_valid), 32'd0);
        step(1);
        checkOutput("add_issued", 32'(iss_valid), 32'd1);
        checkOutput("add_op", 32'(iss_op), 32'd2);
        checkOutput("add_wsel", 32'(iss_wsel), 32'd5);
        checkOutput("add_rsel1", 32'(iss_rsel1), 32'd4);

        // ---------------- queue fill, backpressure, order and wrap
        doReset();
        for (int k = 1; k <= 5; k++) begin
            checkOutput("fill_ready", 32'(fetch_ready), 32'd1);
            applyStimulus(1'b1, 32'h34000000 | (k << 16) | k, 32'h300 + 4 * k);
            step(1);
        end
        checkOutput("full_ready", 32'(fetch_ready), 32'd0);
        checkOutput("full_iss_valid", 32'(iss_valid), 32'd1);
        checkOutput("full_head_imm", 32'(iss_imm16), 32'd1);
        applyStimulus(1'b1, 32'h34060006, 32'h00000318);
        step(2);
        checkOutput("full_hold_ready", 32'(fetch_ready), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0);
        iss_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step(1);
            checkOutput("drain_valid", 32'(iss_valid), 32'd1);
            checkOutput("drain_order", 32'(iss_imm16), 32'(k));
        end
        step(1);
        checkOutput("drain_empty", 32'(iss_valid), 32'd0);
        pushAndIssue(32'h34070007, 32'h00000320);
        checkOutput("wrap_imm", 32'(iss_imm16), 32'd7);
        checkOutput("wrap_npc", iss_npc, 32'h00000320);

        // ---------------- flush
        doReset();
        pushAndIssue(32'h34090009, 32'h00000404);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 32'h34000000 | (k << 16) | k, 32'h400 + 4 * k);
            step(1);
        end
        applyStimulus(1'b1, 32'h340A000A, 32'h00000420);
        flush     = 1'b1;
        iss_ready = 1'b1;
        step(1);
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("flush_iss_valid", 32'(iss_valid), 32'd0);
        checkOutput("flush_ready", 32'(fetch_ready), 32'd1);
        step(2);
        checkOutput("flush_queue_empty", 32'(iss_valid), 32'd0);
        applyStimulus(1'b1, 32'h01205021, 32'h00000424);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(2);
        checkOutput("flush_busy9_kept", 32'(iss_valid), 32'd0);
        wb_valid = 1'b1;
        wb_sel   = 5'd9;
        step(1);
        wb_valid = 1'b0;
        step(1);
        checkOutput("flush_after_wb", 32'(iss_valid), 32'd1);
        checkOutput("flush_after_wsel", 32'(iss_wsel), 32'd10);

        // ---------------- sticky halt
        doReset();
        applyStimulus(1'b1, 32'hFC000000, 32'h00000504);
        step(1);
        applyStimulus(1'b1, 32'h34010001, 32'h00000508);
        step(1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("halt_iss_halt", 32'(iss_halt), 32'd1);
        checkOutput("halt_wen", 32'(iss_WEN), 32'd0);
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_ready", 32'(fetch_ready), 32'd0);
        iss_ready = 1'b1;
        step(3);
        checkOutput("halt_ori_blocked", 32'(iss_valid), 32'd0);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checkOutput("halt_survives_flush", 32'(halted), 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("halt_cleared_by_rst", 32'(halted), 32'd0);

        // ---------------- illegal opcode, write to $0, branch and jump decode
        doReset();
        pushAndIssue(32'hF8000000, 32'h00000604);
        checkOutput("ill_flag", 32'(iss_illegal), 32'd1);
        checkOutput("ill_wen", 32'(iss_WEN), 32'd0);
        checkOutput("ill_dren", 32'(iss_dREN), 32'd0);
        checkOutput("ill_dwen", 32'(iss_dWEN), 32'd0);
        iss_ready = 1'b1;
        pushAndIssue(32'h00220020, 32'h00000608);
        checkOutput("r0_illegal", 32'(iss_illegal), 32'd0);
        checkOutput("r0_wen", 32'(iss_WEN), 32'd1);
        checkOutput("r0_wsel", 32'(iss_wsel), 32'd0);
        pushAndIssue(32'h00003821, 32'h0000060C);
        checkOutput("r0_not_busy", 32'(iss_valid), 32'd1);
        checkOutput("r0_next_wsel", 32'(iss_wsel), 32'd7);
        pushAndIssue(32'h14220003, 32'h00000610);
        checkOutput("bne_valid", 32'(iss_valid), 32'd1);
        checkOutput("bne_brne", 32'(iss_brne), 32'd1);
        checkOutput("bne_pcsel", 32'(iss_pcSel), 32'd1);
        checkOutput("bne_op", 32'(iss_op), 32'd3);
        checkOutput("bne_wen", 32'(iss_WEN), 32'd0);
        checkOutput("bne_rsel2", 32'(iss_rsel2), 32'd2);
        pushAndIssue(32'h0C000010, 32'h00000614);
        checkOutput("jal_valid", 32'(iss_valid), 32'd1);
        checkOutput("jal_wsel", 32'(iss_wsel), 32'd31);
        checkOutput("jal_rfin", 32'(iss_rfInSel), 32'd1);
        checkOutput("jal_pcsel", 32'(iss_pcSel), 32'd3);
        checkOutput("jal_immj", 32'(iss_immJ26), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
